// File: rtl/mem_pkg.sv
// Shared encodings for the memory-access stage: access sizes, FSM states
// and the byte-lane enable helper.
package mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Little-endian lane enables; the illegal size code behaves as a word.
  function automatic logic [3:0] lane_enable(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: lane_enable = 4'b0001 << off;
      SIZE_HALF: lane_enable = off[1] ? 4'b1100 : 4'b0011;
      default:   lane_enable = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: picks the addressed byte/half lane out of the bus word
// and zero- or sign-extends it to the full register width.
module load_align
  import mem_pkg::*;
#(
  parameter int DataWidth = 32
) (
  input  logic [DataWidth-1:0] rdata,
  input  logic [1:0]           off,
  input  logic [1:0]           size,
  input  logic                 is_signed,
  output logic [DataWidth-1:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = rdata[{off, 3'b000} +: 8];
  assign half_lane = rdata[{off[1], 4'b0000} +: 16];

  always_comb begin
    case (size)
      SIZE_BYTE: data = {{(DataWidth-8){is_signed & byte_lane[7]}}, byte_lane};
      SIZE_HALF: data = {{(DataWidth-16){is_signed & half_lane[15]}}, half_lane};
      default:   data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: EX/MEM register, req/ack data-memory bus
// with timeout, load alignment and the MEM/WB register.
module mem_stage
  import mem_pkg::*;
#(
  parameter int DataWidth     = 32,
  parameter int RegAddrWidth  = 5,
  parameter int TimeoutCycles = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ex_valid,
  input  logic [DataWidth-1:0]    data_out_EX,
  input  logic [DataWidth-1:0]    rdata_2_EX,
  input  logic [RegAddrWidth-1:0] target_EX,
  input  logic                    we_reg_EX,
  input  logic                    mem_read_EX,
  input  logic                    mem_write_EX,
  input  logic [1:0]              mem_size_EX,
  input  logic                    mem_signed_EX,
  input  logic [DataWidth-1:0]    hi_EX,
  input  logic [DataWidth-1:0]    lo_EX,
  input  logic                    we_hi_EX,
  input  logic                    we_lo_EX,
  output logic [DataWidth-1:0]    data_out_MEM,
  output logic [DataWidth-1:0]    hi_MEM,
  output logic [DataWidth-1:0]    lo_MEM,
  output logic                    load_in_MEM,
  output logic                    stall_MEM,
  output logic                    dmem_req,
  output logic                    dmem_we,
  output logic [DataWidth-1:0]    dmem_addr,
  output logic [3:0]              dmem_be,
  output logic [DataWidth-1:0]    dmem_wdata,
  input  logic [DataWidth-1:0]    dmem_rdata,
  input  logic                    dmem_ack,
  output logic                    valid_WB,
  output logic                    we_reg_WB,
  output logic                    we_hi_WB,
  output logic                    we_lo_WB,
  output logic [RegAddrWidth-1:0] target_WB,
  output logic [DataWidth-1:0]    data_out_WB,
  output logic [DataWidth-1:0]    hi_WB,
  output logic [DataWidth-1:0]    lo_WB,
  output logic                    addr_err,
  output logic                    bus_err
);

  localparam logic [7:0] CntLast = 8'(TimeoutCycles - 1);

  logic                    s_valid_reg, s_wreg_reg, s_rd_reg, s_wr_reg;
  logic                    s_signed_reg, s_whi_reg, s_wlo_reg;
  logic [1:0]              s_size_reg;
  logic [DataWidth-1:0]    s_data_reg, s_rt_reg, s_hi_reg, s_lo_reg;
  logic [RegAddrWidth-1:0] s_target_reg;

  state_t     state_reg, state_next;
  logic [7:0] cnt_reg, cnt_next;
  logic       timeout_now, mem_op, aligned, null_wr;
  logic [1:0] off, size_eff;
  logic [DataWidth-1:0] load_data;
  logic [3:0][7:0]      wdata_lanes;

  assign off      = s_data_reg[1:0];
  assign size_eff = (s_size_reg == 2'b11) ? SIZE_WORD : s_size_reg;
  assign mem_op   = s_valid_reg & (s_rd_reg | s_wr_reg);
  assign aligned  = (size_eff == SIZE_BYTE) |
                    ((size_eff == SIZE_HALF) & ~off[0]) |
                    ((size_eff == SIZE_WORD) & (off == 2'b00));

  assign dmem_req    = mem_op & aligned & ((state_reg == IDLE) | (state_reg == WAIT));
  assign dmem_we     = dmem_req & s_wr_reg;
  assign dmem_addr   = s_data_reg;
  assign dmem_be     = dmem_req ? lane_enable(size_eff, off) : 4'b0000;
  assign stall_MEM   = dmem_req & ~dmem_ack & ~timeout_now;
  assign addr_err    = mem_op & ~aligned;
  assign bus_err     = timeout_now;
  assign null_wr     = addr_err | timeout_now;
  assign load_in_MEM = s_valid_reg & s_rd_reg;

  assign data_out_MEM = s_data_reg;
  assign hi_MEM       = s_hi_reg;
  assign lo_MEM       = s_lo_reg;

  // Store data replicated across lanes so the enabled lane always carries it.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign wdata_lanes[gi] = (size_eff == SIZE_BYTE) ? s_rt_reg[7:0] :
                               (size_eff == SIZE_HALF) ? s_rt_reg[(gi%2)*8 +: 8] :
                                                         s_rt_reg[gi*8 +: 8];
    end
  endgenerate
  assign dmem_wdata = DataWidth'(wdata_lanes);

  load_align #(.DataWidth(DataWidth)) u_load_align (
    .rdata     (dmem_rdata),
    .off       (off),
    .size      (size_eff),
    .is_signed (s_signed_reg),
    .data      (load_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    timeout_now = 1'b0;
    case (state_reg)
      IDLE: begin
        if (dmem_req && !dmem_ack) begin
          state_next = WAIT;
          cnt_next   = 8'd1;
        end
      end
      WAIT: begin
        if (!dmem_req || dmem_ack) begin
          state_next = IDLE;
          cnt_next   = 8'd0;
        end else if (cnt_reg == CntLast) begin
          timeout_now = 1'b1;
          state_next  = IDLE;
          cnt_next    = 8'd0;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 8'd0;
      end
    endcase
  end

  // EX/MEM: a non-valid slot loads with every write and memory enable cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_valid_reg  <= 1'b0;
      s_wreg_reg   <= 1'b0;
      s_rd_reg     <= 1'b0;
      s_wr_reg     <= 1'b0;
      s_signed_reg <= 1'b0;
      s_whi_reg    <= 1'b0;
      s_wlo_reg    <= 1'b0;
      s_size_reg   <= 2'b00;
      s_data_reg   <= '0;
      s_rt_reg     <= '0;
      s_hi_reg     <= '0;
      s_lo_reg     <= '0;
      s_target_reg <= '0;
    end else if (!stall_MEM) begin
      s_valid_reg  <= ex_valid;
      s_wreg_reg   <= ex_valid & we_reg_EX;
      s_rd_reg     <= ex_valid & mem_read_EX;
      s_wr_reg     <= ex_valid & mem_write_EX;
      s_signed_reg <= mem_signed_EX;
      s_whi_reg    <= ex_valid & we_hi_EX;
      s_wlo_reg    <= ex_valid & we_lo_EX;
      s_size_reg   <= mem_size_EX;
      s_data_reg   <= data_out_EX;
      s_rt_reg     <= rdata_2_EX;
      s_hi_reg     <= hi_EX;
      s_lo_reg     <= lo_EX;
      s_target_reg <= target_EX;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_WB    <= 1'b0;
      we_reg_WB   <= 1'b0;
      we_hi_WB    <= 1'b0;
      we_lo_WB    <= 1'b0;
      target_WB   <= '0;
      data_out_WB <= '0;
      hi_WB       <= '0;
      lo_WB       <= '0;
    end else if (stall_MEM) begin
      valid_WB  <= 1'b0;
      we_reg_WB <= 1'b0;
      we_hi_WB  <= 1'b0;
      we_lo_WB  <= 1'b0;
    end else begin
      valid_WB    <= s_valid_reg;
      we_reg_WB   <= s_wreg_reg & ~null_wr;
      we_hi_WB    <= s_whi_reg & ~null_wr;
      we_lo_WB    <= s_wlo_reg & ~null_wr;
      target_WB   <= s_target_reg;
      data_out_WB <= s_rd_reg ? load_data : s_data_reg;
      hi_WB       <= s_hi_reg;
      lo_WB       <= s_lo_reg;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a transaction-level model of the stage and a
// responding memory, compared against the DUT every cycle.
module tb_mem_stage;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          ex_valid, we_reg_EX, mem_read_EX, mem_write_EX, mem_signed_EX;
  logic          we_hi_EX, we_lo_EX, dmem_ack;
  logic [DW-1:0] data_out_EX, rdata_2_EX, hi_EX, lo_EX, dmem_rdata;
  logic [RW-1:0] target_EX;
  logic [1:0]    mem_size_EX;
  logic [DW-1:0] data_out_MEM, hi_MEM, lo_MEM, dmem_addr, dmem_wdata;
  logic [DW-1:0] data_out_WB, hi_WB, lo_WB;
  logic          load_in_MEM, stall_MEM, dmem_req, dmem_we;
  logic [3:0]    dmem_be;
  logic          valid_WB, we_reg_WB, we_hi_WB, we_lo_WB, addr_err, bus_err;
  logic [RW-1:0] target_WB;

  mem_stage #(.DataWidth(DW), .RegAddrWidth(RW), .TimeoutCycles(TO)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .data_out_EX(data_out_EX),
    .rdata_2_EX(rdata_2_EX), .target_EX(target_EX), .we_reg_EX(we_reg_EX),
    .mem_read_EX(mem_read_EX), .mem_write_EX(mem_write_EX), .mem_size_EX(mem_size_EX),
    .mem_signed_EX(mem_signed_EX), .hi_EX(hi_EX), .lo_EX(lo_EX), .we_hi_EX(we_hi_EX),
    .we_lo_EX(we_lo_EX), .data_out_MEM(data_out_MEM), .hi_MEM(hi_MEM), .lo_MEM(lo_MEM),
    .load_in_MEM(load_in_MEM), .stall_MEM(stall_MEM), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .valid_WB(valid_WB),
    .we_reg_WB(we_reg_WB), .we_hi_WB(we_hi_WB), .we_lo_WB(we_lo_WB),
    .target_WB(target_WB), .data_out_WB(data_out_WB), .hi_WB(hi_WB), .lo_WB(lo_WB),
    .addr_err(addr_err), .bus_err(bus_err)
  );

  typedef struct {
    bit          v, we, rd, wr, sg, whi, wlo;
    logic [31:0] d, rt, hi, lo, rdata;
    logic [4:0]  tg;
    logic [1:0]  sz;
    int          delay;
  } ins_t;

  ins_t m_s, cur, bubble;
  int   m_cyc;
  bit   w_v, w_we, w_whi, w_wlo, w_dchk;
  logic [4:0]  w_tg;
  logic [31:0] w_d, w_hi, w_lo;

  int checks = 0;
  int errors = 0;
  bit spur_ack;
  int stall_seen, req_seen, buserr_idx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit is_mem(input ins_t i);
    return i.v && (i.rd || i.wr);
  endfunction

  function automatic bit is_aligned(input ins_t i);
    return (i.d % nbytes(i.sz)) == 0;
  endfunction

  function automatic logic [3:0] exp_be(input ins_t i);
    return 4'(((1 << nbytes(i.sz)) - 1) << i.d[1:0]);
  endfunction

  function automatic logic [31:0] exp_wdata(input ins_t i);
    int n = nbytes(i.sz);
    if (n == 1) return i.rt[7:0] * 32'h0101_0101;
    if (n == 2) return i.rt[15:0] * 32'h0001_0001;
    return i.rt;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] rdata, input logic [31:0] addr,
                                           input logic [1:0] sz, input bit sg);
    int n = nbytes(sz);
    logic [31:0] mask, v;
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 32'h1);
    v = (rdata >> (8 * addr[1:0])) & mask;
    if (sg && n < 4 && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic ins_t mk(input bit rd, input bit wr, input logic [1:0] sz, input bit sg,
                              input logic [31:0] d, input logic [31:0] rt,
                              input logic [31:0] rdata, input int delay, input bit we);
    ins_t i;
    i.v = 1'b1; i.rd = rd; i.wr = wr; i.sz = sz; i.sg = sg; i.d = d; i.rt = rt;
    i.rdata = rdata; i.delay = delay; i.we = we; i.tg = d[4:0] ^ 5'd9;
    i.hi = d ^ 32'h5A5A_0000; i.lo = rt ^ 32'h0000_A5A5; i.whi = 1'b0; i.wlo = 1'b0;
    return i;
  endfunction

  task automatic drive(input ins_t i);
    cur = i;
    ex_valid = i.v; data_out_EX = i.d; rdata_2_EX = i.rt; target_EX = i.tg;
    we_reg_EX = i.we; mem_read_EX = i.rd; mem_write_EX = i.wr; mem_size_EX = i.sz;
    mem_signed_EX = i.sg; hi_EX = i.hi; lo_EX = i.lo; we_hi_EX = i.whi; we_lo_EX = i.wlo;
  endtask

  task automatic model_reset();
    m_s = bubble; m_cyc = 0;
    w_v = 0; w_we = 0; w_whi = 0; w_wlo = 0; w_dchk = 0; w_tg = '0;
    w_d = '0; w_hi = '0; w_lo = '0;
  endtask

  // One clock cycle: respond as memory, compare, then advance the model.
  task automatic step(output bit accepted);
    bit m_req, m_ack, m_to, m_stall, nul;
    m_req   = is_mem(m_s) && is_aligned(m_s);
    m_ack   = m_req && (m_cyc == m_s.delay);
    m_to    = m_req && !m_ack && (m_cyc == TO - 1);
    m_stall = m_req && !m_ack && !m_to;
    dmem_ack   = m_ack || (!m_req && spur_ack);
    dmem_rdata = m_s.rdata;
    #1;
    chk("req", dmem_req, m_req);
    chk("stall", stall_MEM, m_stall);
    chk("addr_err", addr_err, is_mem(m_s) && !is_aligned(m_s));
    chk("bus_err", bus_err, m_to);
    chk("load_in_mem", load_in_MEM, m_s.v && m_s.rd);
    chk("valid_wb", valid_WB, w_v);
    chk("we_reg_wb", we_reg_WB, w_we);
    chk("we_hi_wb", we_hi_WB, w_whi);
    chk("we_lo_wb", we_lo_WB, w_wlo);
    if (w_v) begin
      chk("target_wb", target_WB, w_tg);
      chk("hi_wb", hi_WB, w_hi);
      chk("lo_wb", lo_WB, w_lo);
      if (w_dchk) chk("data_wb", data_out_WB, w_d);
    end
    if (m_s.v) begin
      chk("data_mem", data_out_MEM, m_s.d);
      chk("hi_mem", hi_MEM, m_s.hi);
      chk("lo_mem", lo_MEM, m_s.lo);
    end
    if (m_req) begin
      chk("dmem_addr", dmem_addr, m_s.d);
      chk("dmem_be", dmem_be, exp_be(m_s));
      chk("dmem_we", dmem_we, m_s.wr);
      if (m_s.wr) chk("dmem_wdata", dmem_wdata, exp_wdata(m_s));
    end
    if (stall_MEM) stall_seen++;
    if (dmem_req) req_seen++;
    if (bus_err) buserr_idx = req_seen;
    @(posedge clk);
    if (m_stall) begin
      w_v = 0; w_we = 0; w_whi = 0; w_wlo = 0;
      m_cyc++;
    end else begin
      nul    = (is_mem(m_s) && !is_aligned(m_s)) || m_to;
      w_v    = m_s.v;
      w_we   = m_s.v && m_s.we && !nul;
      w_whi  = m_s.v && m_s.whi && !nul;
      w_wlo  = m_s.v && m_s.wlo && !nul;
      w_dchk = !nul;
      w_tg   = m_s.tg; w_hi = m_s.hi; w_lo = m_s.lo;
      w_d    = (m_s.v && m_s.rd) ? exp_load(m_s.rdata, m_s.d, m_s.sz, m_s.sg) : m_s.d;
      m_s    = cur;
      if (!cur.v) begin
        m_s.we = 0; m_s.rd = 0; m_s.wr = 0; m_s.whi = 0; m_s.wlo = 0;
      end
      m_cyc  = 0;
    end
    accepted = !m_stall;
    @(negedge clk);
  endtask

  task automatic run(input ins_t i);
    bit acc = 1'b0;
    drive(i);
    for (int k = 0; k < 40; k++) begin
      step(acc);
      if (acc) break;
    end
    if (!acc) chk("accept_bound", 32'd0, 32'd1);
    drive(bubble);
  endtask

  task automatic drain(input int n);
    bit acc;
    for (int k = 0; k < n; k++) step(acc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    ins_t t;
    bit   acc;
    bubble = '{default: 0};
    bubble.delay = 0;
    spur_ack = 0; dmem_ack = 0; dmem_rdata = '0;
    drive(bubble);
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", stall_MEM, 0);
    chk("rst_req", dmem_req, 0);
    chk("rst_valid_wb", valid_WB, 0);
    chk("rst_data_wb", data_out_WB, 0);
    chk("rst_data_mem", data_out_MEM, 0);
    chk("rst_be", dmem_be, 0);
    chk("rst_errs", {addr_err, bus_err, load_in_MEM, dmem_we}, 0);
    rst = 1'b0;

    // Pin the model's load/lane arithmetic against hand-derived values.
    chk("model_lb", exp_load(32'h80FF_FFFF, 32'h103, 2'd0, 1'b1), 32'hFFFF_FF80);
    chk("model_lbu", exp_load(32'h80FF_FFFF, 32'h103, 2'd0, 1'b0), 32'h0000_0080);
    t = mk(0, 1, 2'd1, 0, 32'h102, 32'hABCD_1234, 0, 3, 0);
    chk("model_sh_be", exp_be(t), 4'b1100);
    chk("model_sh_wd", exp_wdata(t), 32'h1234_1234);

    // ALU pass-through
    req_seen = 0;
    t = mk(0, 0, 2'd2, 0, 32'h1234, 32'h0, 0, 0, 1);
    t.whi = 1; t.wlo = 1;
    run(t);
    chk("alu_mem", data_out_MEM, 32'h1234);
    step(acc);
    chk("alu_wb", data_out_WB, 32'h1234);
    chk("alu_valid", valid_WB, 1);
    drain(2);
    chk("alu_noreq", req_seen, 0);

    // LB / LBU, zero-wait
    run(mk(1, 0, 2'd0, 1, 32'h103, 0, 32'h80FF_FFFF, 0, 1));
    chk("lb_be", dmem_be, 4'b1000);
    step(acc);
    chk("lb_wb", data_out_WB, 32'hFFFF_FF80);
    run(mk(1, 0, 2'd0, 0, 32'h103, 0, 32'h80FF_FFFF, 0, 1));
    step(acc);
    chk("lbu_wb", data_out_WB, 32'h0000_0080);

    // SH with three wait cycles, next instruction held upstream
    run(mk(0, 1, 2'd1, 0, 32'h102, 32'hABCD_1234, 0, 3, 0));
    chk("sh_be", dmem_be, 4'b1100);
    chk("sh_wdata", dmem_wdata, 32'h1234_1234);
    chk("sh_we", dmem_we, 1);
    stall_seen = 0;
    run(mk(0, 0, 2'd2, 0, 32'h55, 0, 0, 0, 1));
    chk("sh_stall_cycles", stall_seen, 3);
    drain(2);

    // Misaligned word load
    run(mk(1, 0, 2'd2, 0, 32'h101, 0, 32'h1111_1111, 0, 1));
    chk("lw_mis_err", addr_err, 1);
    chk("lw_mis_req", dmem_req, 0);
    step(acc);
    chk("lw_mis_we", we_reg_WB, 0);

    // Signed half with a wait, illegal size as word, ignored spurious ack
    run(mk(1, 0, 2'd1, 1, 32'h2, 0, 32'h8001_7FFF, 1, 1));
    run(mk(1, 0, 2'd3, 0, 32'h40, 0, 32'hDEAD_BEEF, 0, 1));
    spur_ack = 1;
    drain(3);
    chk("lh_model", exp_load(32'h8001_7FFF, 32'h2, 2'd1, 1'b1), 32'hFFFF_8001);
    spur_ack = 0;
    run(mk(0, 1, 2'd0, 0, 32'h201, 32'h0000_00C3, 0, 2, 0));
    drain(4);

    // Bus timeout
    req_seen = 0; buserr_idx = 0; stall_seen = 0;
    run(mk(1, 0, 2'd2, 0, 32'h200, 0, 32'h7777_7777, 255, 1));
    run(mk(0, 0, 2'd2, 0, 32'h66, 0, 0, 0, 1));
    chk("to_buserr_idx", buserr_idx, TO);
    chk("to_stall_cycles", stall_seen, TO - 1);
    drain(2);

    // Asynchronous reset in the middle of a wait
    run(mk(1, 0, 2'd2, 0, 32'h300, 0, 0, 255, 1));
    drain(2);
    chk("pre_rst_stall", stall_MEM, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_req", dmem_req, 0);
    chk("arst_stall", stall_MEM, 0);
    chk("arst_valid_wb", valid_WB, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    drive(bubble);
    run(mk(0, 0, 2'd2, 0, 32'h99, 0, 0, 0, 1));
    drain(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
